// File: rtl/proc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// proc_pkg : shared types and widths for the 2-stage core front end
// Rev 1.0
// ----------------------------------------------------------------------------
package proc_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int IMM_W   = 16;
  localparam int JT_W    = 26;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    IDLE  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  // Word offset to sign-extended byte offset.
  function automatic logic [PC_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(PC_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/npc_calc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// npc_calc : redirect decision and branch/jump target from execute
// Rev 1.0
// ----------------------------------------------------------------------------
module npc_calc
  import proc_pkg::*;
(
  input  logic             ex_resolve,
  input  logic             ex_branch,
  input  logic             ex_zero,
  input  logic             ex_jump,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [IMM_W-1:0] ex_imm,
  input  logic [JT_W-1:0]  ex_jtarget,
  output logic             taken,
  output logic [PC_W-1:0]  target
);

  logic [PC_W-1:0] pc4;
  logic [PC_W-1:0] btgt;
  logic [PC_W-1:0] jtgt;

  always_comb begin
    pc4    = ex_pc + PC_W'(4);
    btgt   = pc4 + sext_imm(ex_imm);
    jtgt   = {pc4[PC_W-1:PC_W-4], ex_jtarget, 2'b00};
    taken  = ex_resolve && (ex_jump || (ex_branch && ex_zero));
    target = ex_jump ? jtgt : btgt;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_sequencer : PC owner, req/ack imem fetch, one-entry output slot
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_sequencer
  import proc_pkg::*;
#(
  parameter int          IMEM_AW  = 6,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  input  logic               ex_ready,
  input  logic               ex_resolve,
  input  logic               ex_branch,
  input  logic               ex_zero,
  input  logic               ex_jump,
  input  logic [PC_W-1:0]    ex_pc,
  input  logic [IMM_W-1:0]   ex_imm,
  input  logic [JT_W-1:0]    ex_jtarget,
  output logic [PC_W-1:0]    pc,
  output logic [CNT_W-1:0]   flush_cnt
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, pc_inc;
  logic               req_q, req_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    ifpc_q, ifpc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               taken;
  logic [PC_W-1:0]    target;

  npc_calc u_npc_calc (
    .ex_resolve (ex_resolve),
    .ex_branch  (ex_branch),
    .ex_zero    (ex_zero),
    .ex_jump    (ex_jump),
    .ex_pc      (ex_pc),
    .ex_imm     (ex_imm),
    .ex_jtarget (ex_jtarget),
    .taken      (taken),
    .target     (target)
  );

  assign pc_inc = pc_q + PC_W'(4);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    cnt_d   = cnt_q;

    if (valid_q && ex_ready) valid_d = 1'b0;

    unique case (state_q)
      BOOT: state_d = IDLE;
      IDLE: begin
        if (!valid_q || ex_ready) begin
          state_d = WAIT;
          req_d   = 1'b1;
          addr_d  = pc_q[IMEM_AW+1:2];
        end
      end
      WAIT: begin
        if (imem_ack) begin
          // A full, unconsumed slot cannot take the word; it is refetched later.
          if (!valid_q || ex_ready) begin
            valid_d = 1'b1;
            instr_d = imem_rdata;
            ifpc_d  = pc_q;
            pc_d    = pc_inc;
            if (ex_ready) begin
              addr_d = pc_inc[IMEM_AW+1:2];
            end else begin
              state_d = IDLE;
              req_d   = 1'b0;
            end
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
    endcase

    if (taken) begin
      pc_d    = target;
      valid_d = 1'b0;
      instr_d = instr_q;
      ifpc_d  = ifpc_q;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      unique case (state_q)
        WAIT: begin
          req_d = 1'b1;
          if (imem_ack) begin
            state_d = WAIT;
            addr_d  = target[IMEM_AW+1:2];
          end else begin
            state_d = DRAIN;
            addr_d  = addr_q;
          end
        end
        IDLE: begin
          state_d = IDLE;
          req_d   = 1'b0;
          addr_d  = addr_q;
        end
        BOOT, DRAIN: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC[IMEM_AW+1:2];
      valid_q <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_valid  = valid_q;
  assign if_instr  = instr_q;
  assign if_pc     = ifpc_q;
  assign pc        = pc_q;
  assign flush_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_sequencer : directed scenarios plus randomized run vs. stream model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int AW = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        ex_ready, ex_resolve, ex_branch, ex_zero, ex_jump;
  logic [31:0] ex_pc;
  logic [15:0] ex_imm;
  logic [25:0] ex_jtarget;
  logic [31:0] pc;
  logic [15:0] flush_cnt;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [64];
  int lat = 0;
  bit lat_rand = 1'b0;
  int wait_cnt = 0;
  int cur_lat = 0;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .ex_ready(ex_ready), .ex_resolve(ex_resolve), .ex_branch(ex_branch), .ex_zero(ex_zero),
    .ex_jump(ex_jump), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_jtarget(ex_jtarget),
    .pc(pc), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory: answers each request after lat (or random 0..2) idle cycles.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      imem_ack = 1'b0;
      if (rst_n === 1'b1 && imem_req === 1'b1) begin
        if (wait_cnt == 0) cur_lat = lat_rand ? int'($urandom_range(0, 2)) : lat;
        if (wait_cnt >= cur_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr];
          wait_cnt   = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_resolve = 1'b0; ex_branch = 1'b0; ex_zero = 1'b0; ex_jump = 1'b0;
    ex_pc = '0; ex_imm = '0; ex_jtarget = '0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    clear_ex();
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ex_ready = 1'b1; lat = 0; lat_rand = 1'b0;
    clear_ex();
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", pc); end
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imem_req); end
      tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", if_valid); end
      tests++; if (flush_cnt !== 16'h0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
        fails++; $display("FAIL reset_slot: got cnt=%h if_pc=%h instr=%h want all 0", flush_cnt, if_pc, if_instr);
      end
    end
    rst_n = 1'b1;
    tick();
    tests++; if (imem_req !== 1'b0 || pc !== 32'h0 || if_valid !== 1'b0) begin
      fails++; $display("FAIL boot_quiet: got req=%b pc=%h valid=%b want 0/0/0", imem_req, pc, if_valid);
    end
    tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 6'd0) begin
      fails++; $display("FAIL first_req: got req=%b addr=%0d want 1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    ex_ready = 1'b1; lat = 0; lat_rand = 1'b0;
    do_reset(2);
    tick(); tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 6'd0) begin
      fails++; $display("FAIL stream_addr0: got req=%b addr=%0d want 1/0", imem_req, imem_addr);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * k) || if_instr !== mem[k]) begin
        fails++; $display("FAIL stream_slot%0d: got v=%b pc=%h instr=%h want 1/%h/%h", k, if_valid, if_pc, if_instr, 32'(4 * k), mem[k]);
      end
      tests++; if (imem_addr !== 6'(k + 1)) begin
        fails++; $display("FAIL stream_addr%0d: got %0d want %0d", k + 1, imem_addr, k + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    ex_ready = 1'b1; lat = 0; lat_rand = 1'b0;
    do_reset(2);
    repeat (5) tick();
    ex_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== mem[2]) begin
        fails++; $display("FAIL bp_frozen%0d: got v=%b pc=%h instr=%h want 1/8/%h", i, if_valid, if_pc, if_instr, mem[2]);
      end
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL bp_req_drop%0d: got %b want 0", i, imem_req); end
    end
    ex_ready = 1'b1;
    tick();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (if_valid === 1'b1) begin
        seen = 1'b1;
        tests++; if (if_pc !== 32'hC || if_instr !== mem[3]) begin
          fails++; $display("FAIL bp_resume: got pc=%h instr=%h want c/%h", if_pc, if_instr, mem[3]);
        end
      end
    end
    if (!seen) begin tests++; fails++; $display("FAIL bp_resume_timeout: got no if_valid want one"); end
  endtask

  task automatic test_branch();
    ex_ready = 1'b1; lat = 0; lat_rand = 1'b0;
    do_reset(2);
    repeat (6) tick();
    ex_ready = 1'b0;
    repeat (2) tick();
    ex_resolve = 1'b1; ex_branch = 1'b1; ex_zero = 1'b0; ex_pc = 32'h10; ex_imm = 16'hFFFC;
    tick();
    tests++; if (pc !== 32'h10 || if_valid !== 1'b1 || if_pc !== 32'hC || flush_cnt !== 16'd0) begin
      fails++; $display("FAIL br_not_taken: got pc=%h v=%b if_pc=%h cnt=%0d want 10/1/c/0", pc, if_valid, if_pc, flush_cnt);
    end
    ex_zero = 1'b1;
    tick();
    clear_ex();
    tests++; if (pc !== 32'h4) begin fails++; $display("FAIL br_pc: got %h want 4", pc); end
    tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL br_flush: got %b want 0", if_valid); end
    tests++; if (flush_cnt !== 16'd1) begin fails++; $display("FAIL br_cnt: got %0d want 1", flush_cnt); end
    tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 6'd1) begin
      fails++; $display("FAIL br_next_addr: got req=%b addr=%0d want 1/1", imem_req, imem_addr);
    end
  endtask

  task automatic test_jump_drain();
    bit acked, reqd, seen;
    ex_ready = 1'b1; lat = 3; lat_rand = 1'b0;
    do_reset(2);
    tick(); tick();
    ex_resolve = 1'b1; ex_jump = 1'b1; ex_pc = 32'h8; ex_jtarget = 26'h20;
    tick();
    clear_ex();
    acked = 1'b0;
    for (int i = 0; i < 10 && !acked; i++) begin
      tests++; if (imem_req !== 1'b1 || imem_addr !== 6'd0 || if_valid !== 1'b0 || pc !== 32'h80) begin
        fails++; $display("FAIL drain_hold: got req=%b addr=%0d v=%b pc=%h want 1/0/0/80", imem_req, imem_addr, if_valid, pc);
      end
      if (imem_ack === 1'b1) acked = 1'b1;
      else tick();
    end
    if (!acked) begin tests++; fails++; $display("FAIL drain_ack_timeout: got no ack want one"); end
    reqd = 1'b0;
    for (int i = 0; i < 10 && !reqd; i++) begin
      tick();
      tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL drain_leak: got v=1 if_pc=%h want v=0", if_pc); end
      if (imem_req === 1'b1) begin
        reqd = 1'b1;
        tests++; if (imem_addr !== 6'd32) begin fails++; $display("FAIL jump_addr: got %0d want 32", imem_addr); end
      end
    end
    if (!reqd) begin tests++; fails++; $display("FAIL jump_req_timeout: got no req want one"); end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (if_valid === 1'b1) begin
        seen = 1'b1;
        tests++; if (if_pc !== 32'h80 || if_instr !== mem[32]) begin
          fails++; $display("FAIL jump_first: got pc=%h instr=%h want 80/%h", if_pc, if_instr, mem[32]);
        end
      end
    end
    if (!seen) begin tests++; fails++; $display("FAIL jump_valid_timeout: got none want one"); end
  endtask

  task automatic test_wrap();
    ex_ready = 1'b1; lat = 0; lat_rand = 1'b0;
    do_reset(2);
    tick();
    ex_resolve = 1'b1; ex_jump = 1'b1; ex_jtarget = 26'h3F;
    tick();
    clear_ex();
    tests++; if (pc !== 32'hFC || imem_req !== 1'b0) begin
      fails++; $display("FAIL wrap_redirect: got pc=%h req=%b want fc/0", pc, imem_req);
    end
    tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 6'd63) begin
      fails++; $display("FAIL wrap_addr63: got req=%b addr=%0d want 1/63", imem_req, imem_addr);
    end
    tick();
    tests++; if (pc !== 32'h100 || imem_addr !== 6'd0 || if_pc !== 32'hFC || if_instr !== mem[63]) begin
      fails++; $display("FAIL wrap_fetch: got pc=%h addr=%0d if_pc=%h want 100/0/fc", pc, imem_addr, if_pc);
    end
    tick();
    tests++; if (if_pc !== 32'h100 || if_instr !== mem[0]) begin
      fails++; $display("FAIL wrap_next: got if_pc=%h instr=%h want 100/%h", if_pc, if_instr, mem[0]);
    end
  endtask

  task automatic test_saturation();
    ex_ready = 1'b0; lat = 0; lat_rand = 1'b0;
    do_reset(2);
    ex_resolve = 1'b1; ex_jump = 1'b1; ex_jtarget = 26'h20;
    for (int i = 1; i <= 65538; i++) begin
      tick();
      if (i == 65534) begin
        tests++; if (flush_cnt !== 16'hFFFE) begin fails++; $display("FAIL sat_pre: got %h want fffe", flush_cnt); end
      end
      if (i == 65535) begin
        tests++; if (flush_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_reach: got %h want ffff", flush_cnt); end
      end
    end
    clear_ex();
    tests++; if (flush_cnt !== 16'hFFFF || pc !== 32'h80) begin
      fails++; $display("FAIL sat_hold: got cnt=%h pc=%h want ffff/80", flush_cnt, pc);
    end
  endtask

  task automatic test_reset_in_drain();
    ex_ready = 1'b1; lat = 3; lat_rand = 1'b0;
    do_reset(2);
    tick(); tick();
    ex_resolve = 1'b1; ex_jump = 1'b1; ex_pc = 32'h8; ex_jtarget = 26'h20;
    tick();
    clear_ex();
    tests++; if (flush_cnt !== 16'd1 || imem_req !== 1'b1) begin
      fails++; $display("FAIL rd_setup: got cnt=%0d req=%b want 1/1", flush_cnt, imem_req);
    end
    rst_n = 1'b0;
    tick();
    tests++; if (pc !== 32'h0 || imem_req !== 1'b0 || imem_addr !== 6'd0 || if_valid !== 1'b0 ||
                 if_instr !== 32'h0 || if_pc !== 32'h0 || flush_cnt !== 16'h0) begin
      fails++; $display("FAIL rd_reset: got pc=%h req=%b addr=%0d v=%b instr=%h if_pc=%h cnt=%h want all 0",
                        pc, imem_req, imem_addr, if_valid, if_instr, if_pc, flush_cnt);
    end
    rst_n = 1'b1;
  endtask

  // Model: execute sees a sequential stream from 0 that restarts at each taken target.
  task automatic test_random();
    logic [31:0] exp_pc, pc4, tgt;
    int          exp_cnt, consumed, off;
    bit          tk;
    ex_ready = 1'b1; lat = 0; lat_rand = 1'b1;
    do_reset(2);
    exp_pc = 32'h0; exp_cnt = 0; consumed = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      tests++; if (flush_cnt !== 16'(exp_cnt)) begin
        fails++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", cyc, flush_cnt, exp_cnt);
      end
      ex_ready   = ($urandom_range(0, 3) != 0);
      ex_resolve = ($urandom_range(0, 11) == 0);
      ex_branch  = $urandom_range(0, 1) == 1;
      ex_zero    = $urandom_range(0, 1) == 1;
      ex_jump    = $urandom_range(0, 2) == 0;
      ex_pc      = {22'h0, 8'($urandom), 2'b00};
      ex_imm     = 16'($urandom);
      ex_jtarget = 26'($urandom);
      tk  = ex_resolve && (ex_jump || (ex_branch && ex_zero));
      pc4 = ex_pc + 32'd4;
      off = $signed(ex_imm);
      tgt = ex_jump ? ((pc4 & 32'hF000_0000) + ({6'h0, ex_jtarget} * 4)) : (pc4 + 32'(off * 4));
      if (tk) begin
        exp_pc = tgt;
        if (exp_cnt < 65535) exp_cnt++;
      end else if (if_valid === 1'b1 && ex_ready) begin
        consumed++;
        tests++; if (if_pc !== exp_pc || if_instr !== mem[if_pc[AW+1:2]]) begin
          fails++; $display("FAIL rnd_stream@%0d: got pc=%h instr=%h want pc=%h", cyc, if_pc, if_instr, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
    clear_ex();
    tests++; if (consumed < 200) begin fails++; $display("FAIL rnd_progress: got %0d want >=200", consumed); end
    lat_rand = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    rst_n = 1'b0; ex_ready = 1'b0;
    clear_ex();
    test_reset();
    test_stream();
    test_backpressure();
    test_branch();
    test_jump_drain();
    test_wrap();
    test_reset_in_drain();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
